// File: rtl/gray_checker.sv
// gray_checker: samples a Gray count on Valid, decodes it to binary, and checks single forward steps
// Ports:
//   Clk, Reset_n   rising-edge clock, asynchronous active-low reset
//   Valid, Gray    sample strobe and W-bit Gray input
//   Clear          synchronous clear of lock, error and counters (priority over Valid)
//   Bin            registered binary decode of the last sample
//   Locked, Error  reference captured / sticky illegal-step flag
//   Wraps          saturating count of legal max->0 steps
//   Err_count      saturating count of illegal steps
module gray_checker #(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Valid,
  input  logic [W-1:0]     Gray,
  input  logic             Clear,
  output logic [W-1:0]     Bin,
  output logic             Locked,
  output logic             Error,
  output logic [CNT_W-1:0] Wraps,
  output logic [CNT_W-1:0] Err_count
);
  typedef enum logic [1:0] {UNLOCKED, LOCKED, ERR} state_t;
  state_t           state_q;
  logic [W-1:0]     bin_d, bin_q, prev_q;
  logic             locked_q, error_q;
  logic [CNT_W-1:0] wraps_q, errc_q;
  logic             hold, adv, wrap, illegal;
  // binary bit i is the XOR of all Gray bits at or above i
  for (genvar i = 0; i < W; i++) assign bin_d[i] = ^(Gray >> i);
  assign hold    = bin_d == prev_q;
  assign adv     = bin_d == W'(prev_q + 1'b1);
  assign wrap    = adv && (prev_q == '1);
  assign illegal = !hold && !adv;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= UNLOCKED;
      bin_q    <= '0;
      prev_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      wraps_q  <= '0;
      errc_q   <= '0;
    end else if (Clear) begin
      state_q  <= UNLOCKED;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      wraps_q  <= '0;
      errc_q   <= '0;
    end else if (Valid) begin
      bin_q  <= bin_d;
      prev_q <= bin_d;
      if (state_q == UNLOCKED) begin
        state_q  <= LOCKED;
        locked_q <= 1'b1;
      end else if (illegal) begin
        state_q <= ERR;
        error_q <= 1'b1;
        errc_q  <= (errc_q == '1) ? errc_q : errc_q + 1'b1;
      end else if (wrap && state_q == LOCKED) begin
        wraps_q <= (wraps_q == '1) ? wraps_q : wraps_q + 1'b1;
      end
    end
  end
  assign Bin       = bin_q;
  assign Locked    = locked_q;
  assign Error     = error_q;
  assign Wraps     = wraps_q;
  assign Err_count = errc_q;
endmodule

// File: tb/tb_gray_checker.sv
// tb_gray_checker: directed test of gray_checker with an 8-bit and a 2-bit counter instance
module tb_gray_checker;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Valid = 1'b0;
  logic [2:0] Gray = '0;
  logic       Clear = 1'b0;
  logic [2:0] bin, bin_s;
  logic       locked, error, locked_s, error_s;
  logic [7:0] wraps, errc;
  logic [1:0] wraps_s, errc_s;
  int checks = 0;
  int failures = 0;
  always #5 Clk = ~Clk;
  gray_checker #(.W(3), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .Gray(Gray), .Clear(Clear),
    .Bin(bin), .Locked(locked), .Error(error), .Wraps(wraps), .Err_count(errc)
  );
  gray_checker #(.W(3), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .Gray(Gray), .Clear(Clear),
    .Bin(bin_s), .Locked(locked_s), .Error(error_s), .Wraps(wraps_s), .Err_count(errc_s)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [2:0] g, input logic c);
    Valid = v;
    Gray  = g;
    Clear = c;
    @(posedge Clk);
    #1;
  endtask
  logic [2:0] gseq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] bseq [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  initial begin
    #12;
    check("rst_bin", 32'(bin), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_error", 32'(error), 0);
    check("rst_wraps", 32'(wraps), 0);
    check("rst_errc", 32'(errc), 0);
    Reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, gseq[i], 1'b0);
      check($sformatf("full_bin%0d", i), 32'(bin), 32'(bseq[i]));
      check($sformatf("full_locked%0d", i), 32'(locked), 1);
    end
    check("full_wraps", 32'(wraps), 1);
    check("full_error", 32'(error), 0);
    check("full_errc", 32'(errc), 0);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b0, 3'b001, 1'b0);
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b0, 3'b001, 1'b0);
    cyc(1'b1, 3'b001, 1'b0);
    check("hold_bin", 32'(bin), 1);
    check("hold_error", 32'(error), 0);
    check("hold_wraps", 32'(wraps), 0);
    check("hold_locked", 32'(locked), 1);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b1, 3'b000, 1'b0);
    check("skip_lock", 32'(locked), 1);
    check("skip_bin0", 32'(bin), 0);
    cyc(1'b1, 3'b011, 1'b0);
    check("skip_error", 32'(error), 1);
    check("skip_errc1", 32'(errc), 1);
    check("skip_bin2", 32'(bin), 2);
    check("skip_locked", 32'(locked), 1);
    cyc(1'b1, 3'b110, 1'b0);
    check("skip_bin4", 32'(bin), 4);
    check("skip_errc2", 32'(errc), 2);
    cyc(1'b1, 3'b111, 1'b0);
    check("skip_bin5", 32'(bin), 5);
    check("skip_errc_legal", 32'(errc), 2);
    check("skip_sticky", 32'(error), 1);
    cyc(1'b1, 3'b101, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    cyc(1'b1, 3'b000, 1'b0);
    check("err_wraps_frozen", 32'(wraps), 0);
    check("err_errc_after_wrap", 32'(errc), 2);
    cyc(1'b1, 3'b001, 1'b1);
    check("clr_locked", 32'(locked), 0);
    check("clr_error", 32'(error), 0);
    check("clr_errc", 32'(errc), 0);
    check("clr_bin_kept", 32'(bin), 0);
    cyc(1'b1, 3'b011, 1'b0);
    check("relock_locked", 32'(locked), 1);
    check("relock_bin", 32'(bin), 2);
    check("relock_error", 32'(error), 0);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b1, 3'b000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 1; i < 9; i++) cyc(1'b1, gseq[i], 1'b0);
      check($sformatf("sat_wraps%0d", k), 32'(wraps_s), (k < 3) ? k + 1 : 3);
      check($sformatf("wide_wraps%0d", k), 32'(wraps), k + 1);
    end
    check("sat_errc", 32'(errc_s), 0);
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    cyc(1'b1, 3'b110, 1'b0);
    check("pre_rst_bin", 32'(bin), 4);
    Valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_bin", 32'(bin), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_error", 32'(error), 0);
    check("arst_wraps", 32'(wraps), 0);
    check("arst_errc", 32'(errc), 0);
    Reset_n = 1'b1;
    cyc(1'b1, 3'b101, 1'b0);
    check("post_rst_locked", 32'(locked), 1);
    check("post_rst_bin", 32'(bin), 6);
    check("post_rst_error", 32'(error), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
